// File: rtl/press_count_hex.sv
// press_count_hex: synchronised, debounced up/down buttons driving an 8-bit hex count
// Optional auto-repeat on held buttons: define PRESS_COUNT_AUTOREPEAT_EN
module press_count_hex #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int REPEAT_DELAY   = 12500000,
    parameter int REPEAT_PERIOD  = 2500000
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Switch_Up,
    input  logic       i_Switch_Dn,
    output logic [3:0] o_Ones_Num,
    output logic [3:0] o_Tens_Num,
    output logic       o_Update
);
    localparam int DW = $clog2(DEBOUNCE_LIMIT);
    logic [1:0] raw, stable, press, ev;
    logic [7:0] count;
    logic inc, dec;
    assign raw = {i_Switch_Dn, i_Switch_Up};
    for (genvar g = 0; g < 2; g++) begin : g_sw
        logic meta, sync, st, st_q;
        logic [DW-1:0] cnt;
        // two-flop synchroniser, debouncer and previous debounced level for edge detection
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                meta <= 1'b0;
                sync <= 1'b0;
                st   <= 1'b0;
                st_q <= 1'b0;
                cnt  <= '0;
            end else begin
                meta <= raw[g];
                sync <= meta;
                st_q <= st;
                if (sync == st) begin
                    cnt <= '0;
                end else if (cnt == DW'(DEBOUNCE_LIMIT - 1)) begin
                    st  <= sync;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + DW'(1);
                end
            end
        end
        assign stable[g] = st;
        assign press[g]  = st & ~st_q;
`ifdef PRESS_COUNT_AUTOREPEAT_EN
        localparam int RW = $clog2(REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD);
        typedef enum logic [1:0] {IDLE, DELAY, REPEAT} rep_state_t;
        rep_state_t state, state_n;
        logic [RW-1:0] rcnt, rcnt_n;
        logic hold, rep;
        // a repeat is only allowed while this button alone is held
        assign hold = st & ~(&stable);
        // repeat state and cycle counter
        always_ff @(posedge i_Clk or negedge i_Rst_L) begin
            if (!i_Rst_L) begin
                state <= IDLE;
                rcnt  <= '0;
            end else begin
                state <= state_n;
                rcnt  <= rcnt_n;
            end
        end
        // next-state and repeat pulse generation
        always_comb begin
            state_n = state;
            rcnt_n  = rcnt + RW'(1);
            rep     = 1'b0;
            if (!hold) begin
                state_n = IDLE;
                rcnt_n  = '0;
            end else if (state == IDLE) begin
                state_n = press[g] ? DELAY : IDLE;
                rcnt_n  = '0;
            end else if (state == DELAY && rcnt == RW'(REPEAT_DELAY - 1)) begin
                state_n = REPEAT;
                rcnt_n  = '0;
                rep     = 1'b1;
            end else if (state == REPEAT && rcnt == RW'(REPEAT_PERIOD - 1)) begin
                rcnt_n  = '0;
                rep     = 1'b1;
            end
        end
        assign ev[g] = press[g] | rep;
`else
        assign ev[g] = press[g];
`endif
    end
    assign inc = ev[0] & ~ev[1];
    assign dec = ev[1] & ~ev[0];
    // count register; simultaneous up and down events cancel
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            count    <= 8'h00;
            o_Update <= 1'b0;
        end else begin
            count    <= inc ? count + 8'd1 : dec ? count - 8'd1 : count;
            o_Update <= inc | dec;
        end
    end
    assign o_Ones_Num = count[3:0];
    assign o_Tens_Num = count[7:4];
endmodule

// File: doc/press_count_hex.md
# press_count_hex

Debounced two-button up/down counter that produces the 8-bit value shown on the board's two seven-segment digits. Sits directly upstream of the binary-to-seven-segment encoders: `o_Ones_Num` feeds the low-digit encoder and `o_Tens_Num` feeds the high-digit encoder. Raw push-button inputs are synchronised, debounced, and converted into count events. The count wraps between 0x00 and 0xFF.

## Interface
- `DEBOUNCE_LIMIT`, default 250000: cycles a synchronised input must hold a new level before the debounced state flips; minimum 2.
- `REPEAT_DELAY`, default 12500000: cycles a debounced press must be held before the first auto-repeat event (autorepeat builds only).
- `REPEAT_PERIOD`, default 2500000: cycles between later auto-repeat events (autorepeat builds only).
- `i_Clk` input 1: single clock domain; all logic is on the rising edge.
- `i_Rst_L` input 1: reset, asynchronous and active-low; asserting it clears all state immediately.
- `i_Switch_Up` input 1: raw, asynchronous, bouncy button; 1 means pressed; increments the count.
- `i_Switch_Dn` input 1: raw, asynchronous, bouncy button; 1 means pressed; decrements the count.
- `o_Ones_Num` output 4: count[3:0].
- `o_Tens_Num` output 4: count[7:4].
- `o_Update` output 1: one-cycle pulse, high in the first cycle the new count is visible.

## Operation
- Synchroniser:
  - Each raw switch passes through a 2-flop synchroniser.
  - Synchroniser flops reset to 0.
- Debouncer (one per switch):
  - Holds a stable state and a counter sized with `$clog2(DEBOUNCE_LIMIT)`.
  - When the synchronised input equals the stable state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter equals `DEBOUNCE_LIMIT-1`, the stable state takes the synchronised value and the counter clears.
  - Stable state resets to 0 (released).
- Press event: a debounced 0->1 transition. Releases generate no event.
- Count update (8-bit register, reset 0x00):
  - Up event alone: count+1, mod 256. 0xFF -> 0x00.
  - Down event alone: count-1, mod 256. 0x00 -> 0xFF.
  - Up and down events in the same cycle: no change and no `o_Update`.
  - Any change asserts `o_Update` for exactly one cycle, coincident with the new output value.
- Outputs are registered directly from the count register. There is no combinational path from the switches.
- Reset values: `o_Ones_Num`=0, `o_Tens_Num`=0, `o_Update`=0. Debouncers and the repeat FSM are also cleared.
- Reset mid-debounce or mid-hold discards the pending event. A button still held after reset release produces a fresh press event once debounced.

## Timing
- Latency from a raw switch edge (held clean) to the new count and `o_Update`: exactly `DEBOUNCE_LIMIT+3` cycles.
  - 2 cycles for the synchroniser.
  - `DEBOUNCE_LIMIT` cycles for the debouncer.
  - 1 cycle for the count register.
- Glitches on the synchronised input shorter than `DEBOUNCE_LIMIT` cycles are rejected; the counter restarts from 0.
- Maximum event rate is one per cycle per switch. Events are never queued; each is applied in the cycle after it is detected.

## Configuration
- `PRESS_COUNT_AUTOREPEAT_EN` defined: one repeat FSM per switch with states IDLE, DELAY and REPEAT.
  - IDLE -> DELAY on a press event; the cycle counter loads 0.
  - DELAY -> REPEAT when the counter reaches `REPEAT_DELAY-1`; this emits one repeat event.
  - In REPEAT, one repeat event is emitted every `REPEAT_PERIOD` cycles.
  - Any state -> IDLE when the debounced state goes to 0.
  - Repeat events are treated identically to press events, including up/down cancellation.
  - If both switches are debounced-high, both FSMs are forced to IDLE, so no repeats occur.
- `PRESS_COUNT_AUTOREPEAT_EN` undefined:
  - No FSM logic is built and `REPEAT_*` are ignored.
  - A hold produces exactly one event.

## Test plan
Bench uses `DEBOUNCE_LIMIT`=4, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=5.
- Reset: assert `i_Rst_L`=0 asynchronously mid-cycle -> outputs 0/0/0 immediately. Release with both switches low -> outputs stay 0 and there is no `o_Update`.
- Single press: `i_Switch_Up` high for 30 cycles -> `o_Ones_Num`=1 exactly 7 cycles after the edge, `o_Update` high for 1 cycle. Release produces no change.
- Bounce rejection: `i_Switch_Up` toggled with pulses of 1-3 cycles for 40 cycles, then low -> count stays 0 and `o_Update` never asserts.
- Wrap: from reset, one down press -> `o_Tens_Num`=F and `o_Ones_Num`=F. Then one up press -> 0/0. Each change gives one `o_Update`.
- Simultaneous: both switches rise in the same cycle and are held 10 cycles -> count unchanged and no `o_Update`.
- Autorepeat (macro defined): `i_Switch_Up` held for 50 cycles from count 0 -> values 1, 2, 3, 4, 5, 6 at cycles 7, 27, 32, 37, 42, 47 after the edge. Macro undefined: count = 1 only.
